// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel switch debouncer.
package debounce_pkg;

  localparam int   DEF_NCH       = 4;
  localparam int   DEF_CNT_W     = 6;
  localparam int   DEF_HOLD_W    = 8;
  localparam logic DEF_RESET_VAL = 1'b0;

  // Clock cycles from the first edge that samples a new level to the edge
  // where db shows it, with ce held high.
  function automatic int settle_latency(input int cnt_w);
    return (1 << (cnt_w - 1)) + 2;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: two-flop synchroniser, settle counter that restarts
// on any input change, registered level/edge outputs, and a long-press timer.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   CNT_W     = DEF_CNT_W,
  parameter int   HOLD_W    = DEF_HOLD_W,
  parameter logic RESET_VAL = DEF_RESET_VAL
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic switch,
  output logic db,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] H_ONE   = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] H_MAX   = {HOLD_W{1'b1}};
  localparam logic [HOLD_W-1:0] H_MAXM1 = H_MAX - H_ONE;

  logic              s1;
  logic              s2;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hcnt;
  logic              change;
  logic              settled;

  assign change  = s1 ^ s2;
  // The counter saturates at its MSB, so the MSB alone marks "stable long enough".
  assign settled = cnt[CNT_W-1];

  // Synchroniser flops for the asynchronous pin.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= switch;
      s2 <= s1;
    end
  end

  // Settle counter: any change restarts it immediately, even without ce.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (change) begin
      cnt <= '0;
    end else if (ce && !settled) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Accept the synchronised level once settled; edges fire alongside the new db.
  always_ff @(posedge clock) begin
    if (reset) begin
      db   <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (settled) begin
      db   <= s2;
      rise <= s2 & ~db;
      fall <= ~s2 & db;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

  // Long-press timer: counts ce ticks while db is high, sticks at max so the
  // hold pulse fires once per high period.
  always_ff @(posedge clock) begin
    if (reset) begin
      hcnt <= '0;
      hold <= 1'b0;
    end else begin
      if (!db) begin
        hcnt <= '0;
      end else if (ce && (hcnt != H_MAX)) begin
        hcnt <= hcnt + H_ONE;
      end
      hold <= db & ce & (hcnt == H_MAXM1);
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// NCH independent debounce channels sharing one clock, reset and ce tick.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int   NCH       = DEF_NCH,
  parameter int   CNT_W     = DEF_CNT_W,
  parameter int   HOLD_W    = DEF_HOLD_W,
  parameter logic RESET_VAL = DEF_RESET_VAL
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ce,
  input  logic [NCH-1:0] switch,
  output logic [NCH-1:0] db,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic [NCH-1:0] hold
);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    debounce_chan #(
      .CNT_W     (CNT_W),
      .HOLD_W    (HOLD_W),
      .RESET_VAL (RESET_VAL)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .ce     (ce),
      .switch (switch[gi]),
      .db     (db[gi]),
      .rise   (rise[gi]),
      .fall   (fall[gi]),
      .hold   (hold[gi])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with NCH=4, CNT_W=4, HOLD_W=3.
// Expected timing (ce=1): db/rise/fall at edge 10 after the first sampling
// edge E0, hold at edge 17.
module tb_debounce_multi;

  logic       clock = 1'b0;
  logic       reset;
  logic       ce;
  logic [3:0] switch;
  logic [3:0] db;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] hold;

  int compared   = 0;
  int mismatched = 0;

  debounce_multi #(
    .NCH       (4),
    .CNT_W     (4),
    .HOLD_W    (3),
    .RESET_VAL (1'b0)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .switch (switch),
    .db     (db),
    .rise   (rise),
    .fall   (fall),
    .hold   (hold)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    obs = {db, rise, fall, hold};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed db/rise/fall/hold=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  // Runs n edges after the caller changed switch[ch]; k=0 is E0.
  task automatic window(input string tag, input int n, input int ch,
                        input logic [3:0] base_db, input logic new_lvl,
                        input int t_db, input int t_hold, input bit gate_ce);
    logic [3:0] e_db, e_r, e_f, e_h;
    for (int k = 0; k < n; k++) begin
      if (gate_ce) ce = ((k % 4) == 0);
      tick();
      e_db = base_db;
      e_r = 4'b0;
      e_f = 4'b0;
      e_h = 4'b0;
      if (k >= t_db) e_db[ch] = new_lvl;
      if (k == t_db) begin
        if (new_lvl) e_r[ch] = 1'b1;
        else         e_f[ch] = 1'b1;
      end
      if (k == t_hold) e_h[ch] = 1'b1;
      chk($sformatf("%s_k%0d", tag, k), {e_db, e_r, e_f, e_h});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    ce     = 1'b1;
    switch = 4'b0000;
    repeat (3) tick();
    chk("in_reset", 16'h0000);
    reset = 1'b0;
    // Inputs equal to the reset value settle with no pulses.
    for (int k = 0; k < 15; k++) begin
      tick();
      chk($sformatf("quiet_k%0d", k), 16'h0000);
    end

    // Clean step on channel 0.
    switch[0] = 1'b1;
    window("clean", 21, 0, 4'b0000, 1'b1, 10, 17, 1'b0);

    // Bounce on channel 1: 5-cycle runs never reach the settle count.
    for (int t = 0; t < 60; t++) begin
      switch[1] = (((t / 5) % 2) == 0);
      tick();
      chk($sformatf("bounce_t%0d", t), {4'b0001, 12'h000});
    end
    switch[1] = 1'b1;
    window("bounce_final", 21, 1, 4'b0001, 1'b1, 10, 17, 1'b0);

    // Channel 2 goes high, then a 3-cycle low glitch must leave it untouched.
    switch[2] = 1'b1;
    window("ch2_up", 21, 2, 4'b0011, 1'b1, 10, 17, 1'b0);
    for (int k = 0; k < 28; k++) begin
      switch[2] = (k >= 3);
      tick();
      chk($sformatf("glitch_k%0d", k), {4'b0111, 12'h000});
    end

    // Release channel 0, then press again: hold must fire anew.
    switch[0] = 1'b0;
    window("release", 13, 0, 4'b0111, 1'b0, 10, -1, 1'b0);
    switch[0] = 1'b1;
    window("repress", 21, 0, 4'b0110, 1'b1, 10, 17, 1'b0);

    // ce every 4th cycle on channel 3: restart at E1 happens with ce=0,
    // 8 ticks at E4..E32, db at E33; hold after 6 more ticks plus one (E60).
    switch[3] = 1'b1;
    window("ce_gate", 66, 3, 4'b0111, 1'b1, 33, 60, 1'b1);
    ce = 1'b1;

    // Drop everything, then reset in the middle of a channel-3 settle.
    switch = 4'b0000;
    repeat (15) tick();
    chk("all_low", 16'h0000);
    switch[3] = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("reset_mid", 16'h0000);
    reset = 1'b0;
    window("after_reset", 13, 3, 4'b0000, 1'b1, 10, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
